blink_sequencer: RTL and testbench
==================================

# blink_sequencer

Blink-burst controller for a single status LED on the icestick. It accepts a blink configuration (burst length, half-period) over a valid/ready command port and emits repeating bursts of N blinks separated by a fixed gap. It owns and restarts its own tick prescaler, so every phase has an exact cycle-level duration. It sits between the board control logic and the LED pin, replacing free-running blink counters.

## Interface
- TICK_DIV, default 120_000: i_clk cycles per tick (10 ms at 12 MHz); must be ≥2.
- GAP_TICKS, default 50: ticks of LED-off gap between bursts; must be ≥1.
- i_clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_count  input  4  blinks per burst; 0 = stop.
- cmd_period  input  8  ON and OFF half-period in ticks; 0 is treated as 1.
- led  output  1  LED drive (registered).
- busy  output  1  high in any state other than IDLE.
- burst_done  output  1  one-cycle pulse when a burst's last OFF phase ends.

## Operation
- Registers:
  - active config: cnt_a, per_a.
  - pending config: cnt_p, per_p, with flag pend.
  - prescaler: width $clog2(TICK_DIV).
  - tick timer: 8 bits, or wide enough for GAP_TICKS.
  - blink counter: 4 bits.
- cmd_ready = !pend. A handshake loads cnt_p and per_p and sets pend.
- FSM states IDLE, ON, OFF, GAP.
- IDLE: led=0. If pend && cnt_p≠0: copy pending to active, clear pend, go to ON. If pend && cnt_p=0: clear pend, stay in IDLE.
- ON: led=1 for per_a ticks, then go to OFF.
- OFF: led=0 for per_a ticks. At the end, increment the blink counter.
  - If blinks < cnt_a: go to ON.
  - Otherwise: pulse burst_done and go to GAP.
- GAP: led=0 for GAP_TICKS ticks. At the end:
  - If pend && cnt_p=0: clear pend, go to IDLE.
  - If pend && cnt_p≠0: load pending to active, clear pend, go to ON.
  - Otherwise: go to ON with the current active config.
- The blink counter clears on every entry to ON from IDLE or GAP.
- A new command never interrupts a burst in progress. It takes effect only at an IDLE or GAP exit.
- Phase entry restarts the prescaler and the tick timer to 0. A tick is the cycle the prescaler reaches TICK_DIV-1. The phase ends on the tick that brings the timer to its limit.
- Effective period = (cmd_period==0) ? 1 : cmd_period, applied at load time.

## Timing
- Reset values:
  - FSM = IDLE; led=0, busy=0, burst_done=0, cmd_ready=1.
  - pend=0; all counters 0.
- The FSM and all outputs are registered. led changes in the same cycle as the state register.
- Latency: a command accepted in IDLE at cycle t sets pend at t+1, and led=1 and busy=1 at t+2.
- Phase durations, exact:
  - ON = per_a × TICK_DIV cycles.
  - OFF = per_a × TICK_DIV cycles.
  - GAP = GAP_TICKS × TICK_DIV cycles.
- Burst period = (2·cnt_a·per_a + GAP_TICKS) × TICK_DIV cycles.
- burst_done asserts in the first cycle of GAP, for exactly 1 cycle.
- With pend set, cmd_ready=0 until the pending config is consumed. cmd_ready returns to 1 the cycle after pend clears.
- Simultaneous consume and new handshake is impossible, since cmd_ready=0 while pend=1.
- rst low at any time, including mid-phase or mid-handshake, returns everything to reset values on the next edge. The pending command is discarded.

## Test plan
- Reset, TICK_DIV=4, GAP_TICKS=5, cmd (count=2, period=3) accepted in IDLE:
  - led high 2 cycles after the handshake.
  - Pattern: ON 12, OFF 12, ON 12, OFF 12.
  - burst_done at the first GAP cycle, then GAP 20 cycles, then repeat.
- Period 0: cmd (count=1, period=0) gives ON 4, OFF 4, GAP 20 cycles.
- Stop: cmd count=0 issued mid-ON during a running burst:
  - cmd_ready falls the next cycle.
  - The burst completes, then IDLE at the GAP end: led=0, busy=0, cmd_ready=1.
- Reconfigure: cmd (count=3, period=1) issued during the OFF of a count=2 burst:
  - The current burst still shows 2 blinks.
  - The next burst shows 3 blinks of 4/4 cycles.
- Back-pressure: hold cmd_valid high with changing data while pend=1.
  - No data is accepted until pend clears.
  - The accepted value is the one present on the first cycle with cmd_ready=1.
- Reset mid-ON:
  - The next edge gives led=0, busy=0, cmd_ready=1.
  - No burst_done pulses.
  - Output stays idle until a new command.

Source files
------------

// File: rtl/blink_sequencer.sv
// rtl/blink_sequencer.sv - burst blink controller for a single status LED
// Bursts of cnt_a blinks (per_a ticks ON, per_a ticks OFF) separated by a GAP_TICKS-tick gap.
module blink_sequencer #(
  parameter int TICK_DIV  = 120_000,
  parameter int GAP_TICKS = 50
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_count,
  input  logic [7:0] cmd_period,
  output logic       led,
  output logic       busy,
  output logic       burst_done
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int TW = (GW > 8) ? GW : 8;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t        state_q;
  logic [PW-1:0] pre_q;
  logic [TW-1:0] tmr_q;
  logic [3:0]    blink_q;
  logic [3:0]    cnt_a_q;
  logic [7:0]    per_a_q;
  logic [3:0]    cnt_p_q;
  logic [7:0]    per_p_q;
  logic          pend_q;
  logic          led_q;
  logic          busy_q;
  logic          done_q;

  logic          tick;
  logic          phase_end;
  logic          accept;
  logic [TW-1:0] limit;
  logic [7:0]    period_eff;
  logic [4:0]    blinks_next;

  always_comb begin
    tick        = (pre_q == PW'(TICK_DIV - 1));
    limit       = (state_q == S_GAP) ? TW'(GAP_TICKS) : TW'(per_a_q);
    phase_end   = tick && ((tmr_q + TW'(1)) == limit);
    accept      = cmd_valid && !pend_q;
    period_eff  = (cmd_period == 8'd0) ? 8'd1 : cmd_period;
    blinks_next = {1'b0, blink_q} + 5'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      tmr_q   <= '0;
      blink_q <= '0;
      cnt_a_q <= '0;
      per_a_q <= '0;
      cnt_p_q <= '0;
      per_p_q <= '0;
      pend_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pre_q  <= tick ? '0 : pre_q + PW'(1);
      if (tick) tmr_q <= tmr_q + TW'(1);

      // Handshake and consume never coincide: accept requires pend_q low.
      if (accept) begin
        cnt_p_q <= cmd_count;
        per_p_q <= period_eff;
        pend_q  <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            pend_q <= 1'b0;
            if (cnt_p_q != 4'd0) begin
              cnt_a_q <= cnt_p_q;
              per_a_q <= per_p_q;
              blink_q <= '0;
              pre_q   <= '0;
              tmr_q   <= '0;
              state_q <= S_ON;
              led_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        S_ON: begin
          if (phase_end) begin
            pre_q   <= '0;
            tmr_q   <= '0;
            state_q <= S_OFF;
            led_q   <= 1'b0;
          end
        end
        S_OFF: begin
          if (phase_end) begin
            pre_q   <= '0;
            tmr_q   <= '0;
            blink_q <= blinks_next[3:0];
            if (blinks_next < {1'b0, cnt_a_q}) begin
              state_q <= S_ON;
              led_q   <= 1'b1;
            end else begin
              state_q <= S_GAP;
              done_q  <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (phase_end) begin
            pre_q   <= '0;
            tmr_q   <= '0;
            blink_q <= '0;
            if (pend_q && cnt_p_q == 4'd0) begin
              pend_q  <= 1'b0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              if (pend_q) begin
                pend_q  <= 1'b0;
                cnt_a_q <= cnt_p_q;
                per_a_q <= per_p_q;
              end
              state_q <= S_ON;
              led_q   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !pend_q;
  assign led        = led_q;
  assign busy       = busy_q;
  assign burst_done = done_q;
endmodule

// File: tb/tb_blink_sequencer.sv
// tb/tb_blink_sequencer.sv - self-checking bench for blink_sequencer
// Directed burst-shape vectors, corner sequences and a randomized run against a schedule model.
module tb_blink_sequencer;
  localparam int TD = 4;
  localparam int GT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_count = 4'd0;
  logic [7:0] cmd_period = 8'd0;
  wire        cmd_ready;
  wire        led;
  wire        busy;
  wire        burst_done;

  int n_tests = 0;
  int n_fail  = 0;

  blink_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .i_clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_period(cmd_period),
    .led(led), .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] cnt;
    logic [7:0] per;
    int lat;
    int on_len;
    int off_len;
    int gap_len;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Returns at the negedge of the cycle after the handshake edge.
  task automatic send(input logic [3:0] c, input logic [7:0] p);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_count = c;
    cmd_period = p;
    while (!cmd_ready && w < 3000) begin @(negedge clk); w++; end
    check("send_ready", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_for(input string name, input bit on_done);
    int w = 0;
    while (!(on_done ? burst_done : led) && w < 3000) begin @(negedge clk); w++; end
    check(name, int'(on_done ? burst_done : led), 1);
  endtask

  // Length of the run of led==v starting now; dpos = offset of a burst_done pulse inside it.
  task automatic run_len(input logic v, output int len, output int dpos);
    len = 0;
    dpos = -1;
    while (led == v && len < 2500) begin
      if (burst_done && dpos < 0) dpos = len;
      len++;
      @(negedge clk);
    end
  endtask

  task automatic measure_burst(output int blinks, output int on_len);
    int w = 0;
    int len, dpos;
    blinks = 0;
    on_len = -1;
    dpos = -1;
    while (!led && w < 2500) begin @(negedge clk); w++; end
    while (dpos < 0 && blinks < 20) begin
      run_len(1'b1, len, dpos);
      if (on_len < 0) on_len = len;
      run_len(1'b0, len, dpos);
      blinks++;
    end
  endtask

  // Reference model: bursts are a timeline from burst start, led and pulses follow from arithmetic.
  bit m_idle, m_pend;
  int m_cp, m_pp, m_c, m_p, m_off;

  task automatic model_reset();
    m_idle = 1; m_pend = 0; m_cp = 0; m_pp = 0; m_c = 0; m_p = 0; m_off = 0;
  endtask

  task automatic model_step();
    bit hs;
    if (!rst) begin
      model_reset();
    end else begin
      hs = cmd_valid && !m_pend;
      if (m_idle) begin
        if (m_pend) begin
          m_pend = 0;
          if (m_cp != 0) begin m_idle = 0; m_c = m_cp; m_p = m_pp; m_off = 0; end
        end
      end else if (m_off == (2 * m_c * m_p + GT) * TD - 1) begin
        m_off = 0;
        if (m_pend) begin
          m_pend = 0;
          if (m_cp == 0) m_idle = 1;
          else begin m_c = m_cp; m_p = m_pp; end
        end
      end else begin
        m_off++;
      end
      if (hs) begin
        m_pend = 1;
        m_cp = int'(cmd_count);
        m_pp = (cmd_period == 8'd0) ? 1 : int'(cmd_period);
      end
    end
  endtask

  function automatic int model_out();
    bit e_led, e_done;
    e_led  = !m_idle && (m_off < 2 * m_c * m_p * TD) && ((m_off % (2 * m_p * TD)) < m_p * TD);
    e_done = !m_idle && (m_off == 2 * m_c * m_p * TD);
    return {28'd0, e_led, !m_idle, e_done, !m_pend};
  endfunction

  initial begin
    int len, dpos, lat, bl, onl, any, fail0, cnt;

    vecs[0] = '{cnt: 4'd2,  per: 8'd3,   lat: 2, on_len: 12,   off_len: 12,   gap_len: 20};
    vecs[1] = '{cnt: 4'd1,  per: 8'd0,   lat: 2, on_len: 4,    off_len: 4,    gap_len: 20};
    vecs[2] = '{cnt: 4'd3,  per: 8'd1,   lat: 2, on_len: 4,    off_len: 4,    gap_len: 20};
    vecs[3] = '{cnt: 4'd15, per: 8'd2,   lat: 2, on_len: 8,    off_len: 8,    gap_len: 20};
    vecs[4] = '{cnt: 4'd1,  per: 8'd255, lat: 2, on_len: 1020, off_len: 1020, gap_len: 20};

    @(negedge clk);
    reset_dut();
    check("reset_led", int'(led), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(burst_done), 0);
    check("reset_ready", int'(cmd_ready), 1);

    for (int k = 0; k < 5; k++) begin
      reset_dut();
      send(vecs[k].cnt, vecs[k].per);
      lat = 1;
      while (!led && lat < 50) begin @(negedge clk); lat++; end
      check("latency", lat, vecs[k].lat);
      for (int b = 0; b < int'(vecs[k].cnt); b++) begin
        run_len(1'b1, len, dpos);
        check("on_len", len, vecs[k].on_len);
        run_len(1'b0, len, dpos);
        if (b < int'(vecs[k].cnt) - 1) begin
          check("off_len", len, vecs[k].off_len);
        end else begin
          check("off_gap_len", len, vecs[k].off_len + vecs[k].gap_len);
          check("done_pos", dpos, vecs[k].off_len);
        end
      end
      run_len(1'b1, len, dpos);
      check("repeat_on_len", len, vecs[k].on_len);
      check("repeat_busy", int'(busy), 1);
    end

    // Stop command mid-ON: burst completes, then idle at gap end.
    reset_dut();
    send(4'd2, 8'd3);
    wait_for("stop_led", 1'b0);
    repeat (3) @(negedge clk);
    send(4'd0, 8'd0);
    check("stop_ready_low", int'(cmd_ready), 0);
    wait_for("stop_done", 1'b1);
    cnt = 0;
    while (busy && cnt < 500) begin @(negedge clk); cnt++; end
    check("stop_gap_to_idle", cnt, GT * TD);
    check("stop_led_off", int'(led), 0);
    check("stop_ready_high", int'(cmd_ready), 1);

    // Reconfigure during OFF of a count=2 burst.
    reset_dut();
    send(4'd2, 8'd2);
    wait_for("reconf_led", 1'b0);
    run_len(1'b1, len, dpos);
    send(4'd3, 8'd1);
    wait_for("reconf_led2", 1'b0);
    run_len(1'b1, len, dpos);
    check("reconf_old_on", len, 8);
    run_len(1'b0, len, dpos);
    check("reconf_old_end", dpos, 8);
    measure_burst(bl, onl);
    check("reconf_new_blinks", bl, 3);
    check("reconf_new_on", onl, 4);

    // Back-pressure: valid held high with changing data while pend is set.
    reset_dut();
    send(4'd1, 8'd2);
    wait_for("bp_led", 1'b0);
    cmd_valid = 1'b1;
    cmd_count = 4'd2;
    cmd_period = 8'd1;
    @(negedge clk);
    cnt = 0;
    while (!cmd_ready && cnt < 3000) begin
      cmd_count = 4'($urandom_range(4, 15));
      cmd_period = 8'($urandom_range(3, 9));
      @(negedge clk);
      cnt++;
    end
    check("bp_ready_back", int'(cmd_ready), 1);
    cmd_count = 4'd3;
    cmd_period = 8'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    run_len(1'b1, len, dpos);
    check("bp_a_on_rest", len, 3);
    run_len(1'b0, len, dpos);
    check("bp_a_off1", len, 4);
    run_len(1'b1, len, dpos);
    check("bp_a_on2", len, 4);
    run_len(1'b0, len, dpos);
    check("bp_a_done", dpos, 4);
    measure_burst(bl, onl);
    check("bp_b_blinks", bl, 3);
    check("bp_b_on", onl, 4);

    // Reset mid-ON.
    reset_dut();
    send(4'd2, 8'd3);
    wait_for("rst_led", 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_done", int'(burst_done), 0);
    rst = 1'b1;
    any = 0;
    repeat (150) begin
      @(negedge clk);
      if (led || busy || burst_done) any++;
    end
    check("rst_stays_idle", any, 0);

    // Randomized run against the model, including occasional resets.
    reset_dut();
    model_reset();
    fail0 = n_fail;
    for (int i = 0; i < 6000; i++) begin
      check("random_outputs", {28'd0, led, busy, burst_done, cmd_ready}, model_out());
      if (n_fail - fail0 >= 10) break;
      rst = ($urandom_range(0, 1499) != 0);
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_count = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      cmd_period = 8'($urandom_range(0, 3));
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
